// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler
//
// Walks the convolution engine across every (filter, output row, output col)
// position of one pass. It issues one job per position over a valid/ready
// handshake, caps the number of unacknowledged jobs at MAX_OUT, and pulses
// done once the final job has been acknowledged.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   start             begin a pass (only looked at while idle)
//   abort             cancel the current pass, no done pulse
//   busy              pass in progress (issuing or draining)
//   done              one-cycle pulse at the end of a completed pass
//   job_valid/ready   job handshake towards the engine
//   job_filt/row/col  coordinates of the offered job
//   job_last          offered job is the final one of the pass
//   ack               engine finished one job (in issue order)
//   stall_cycles      (only with CONV_SCHED_PERF_EN) cycles spent issuing
//                     without a handshake; cleared on start, saturating
//
// Optional feature macro: CONV_SCHED_PERF_EN
module conv_job_scheduler #(
    parameter int DIM1    = 2,
    parameter int DIM2    = 2,
    parameter int DIM3    = 6,
    parameter int IMG_H   = 28,
    parameter int IMG_W   = 28,
    parameter int STRIDE  = 1,
    parameter int MAX_OUT = 4,
    localparam int OUT_H  = (IMG_H - DIM1) / STRIDE + 1,
    localparam int OUT_W  = (IMG_W - DIM2) / STRIDE + 1,
    localparam int FILT_W = (DIM3 > 1) ? $clog2(DIM3) : 1,
    localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int CNT_W  = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              job_valid,
    input  logic              job_ready,
    output logic [FILT_W-1:0] job_filt,
    output logic [ROW_W-1:0]  job_row,
    output logic [COL_W-1:0]  job_col,
    output logic              job_last,
    input  logic              ack
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  outst_q, outst_d;

    logic handshake;
    logic ack_eff;
    logic at_last;

    // Job valid uses the registered outstanding count only, so an ack in
    // the same cycle cannot open the window early.
    assign job_valid = (state_q == ISSUE) && (outst_q < CNT_W'(MAX_OUT));
    assign handshake = job_valid && job_ready;
    assign at_last   = (filt_q == FILT_W'(DIM3 - 1)) &&
                       (row_q == ROW_W'(OUT_H - 1)) &&
                       (col_q == COL_W'(OUT_W - 1));
    assign job_last  = job_valid && at_last;
    // An ack with nothing outstanding (e.g. a late one after abort) is dropped.
    assign ack_eff   = ack && (outst_q != '0);

    assign job_filt  = filt_q;
    assign job_row   = row_q;
    assign job_col   = col_q;
    assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        filt_d  = filt_q;
        row_d   = row_q;
        col_d   = col_q;
        outst_d = outst_q;

        if (handshake && !ack_eff) begin
            outst_d = outst_q + CNT_W'(1);
        end else if (!handshake && ack_eff) begin
            outst_d = outst_q - CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    filt_d  = '0;
                    row_d   = '0;
                    col_d   = '0;
                    outst_d = '0;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    // Column is innermost; each wrap carries outward.
                    if (col_q == COL_W'(OUT_W - 1)) begin
                        col_d = '0;
                        if (row_q == ROW_W'(OUT_H - 1)) begin
                            row_d  = '0;
                            filt_d = (filt_q == FILT_W'(DIM3 - 1)) ? '0 : filt_q + FILT_W'(1);
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (at_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Looking at the next count lets the final ack finish the
                // pass without waiting an extra cycle.
                if (outst_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            filt_d  = '0;
            row_d   = '0;
            col_d   = '0;
            outst_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            filt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            outst_q <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            outst_q <= outst_d;
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Restart the count when a pass is accepted; otherwise count issue-state
    // cycles with no handshake, sticking at the maximum.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start && !abort) begin
            stall_d = '0;
        end else if ((state_q == ISSUE) && !handshake && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
